// File: rtl/qbert_pkg.sv
// rtl/qbert_pkg.sv - shared types and constants for the Qbert move scheduler
package qbert_pkg;

    localparam int POS_W = 28;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        COMMIT    = 3'd4
    } mv_state_t;

    typedef enum logic [1:0] {
        UP_RIGHT   = 2'd0,
        UP_LEFT    = 2'd1,
        DOWN_RIGHT = 2'd2,
        DOWN_LEFT  = 2'd3
    } dir_t;

endpackage

// File: rtl/move_scheduler_if.sv
// rtl/move_scheduler_if.sv - requester and move-engine signal bundle for move_scheduler
//
// master: requesters + move engine side (drives req, req_dir, done_move, position_qb)
// slave : move_scheduler side (drives mv_start, mv_dir, mv_id, ack, pos_out, busy, timeout_err)
interface move_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int POS_W = qbert_pkg::POS_W
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     req_dir;
    logic                  done_move;
    logic [POS_W-1:0]      position_qb;
    logic                  mv_start;
    logic [1:0]            mv_dir;
    logic [ID_W-1:0]       mv_id;
    logic [NREQ-1:0]       ack;
    logic [NREQ*POS_W-1:0] pos_out;
    logic                  busy;
    logic                  timeout_err;

    modport master (
        output req, req_dir, done_move, position_qb,
        input  mv_start, mv_dir, mv_id, ack, pos_out, busy, timeout_err
    );

    modport slave (
        input  req, req_dir, done_move, position_qb,
        output mv_start, mv_dir, mv_id, ack, pos_out, busy, timeout_err
    );
endinterface

// File: rtl/move_scheduler_rr_arbiter.sv
// rtl/move_scheduler_rr_arbiter.sv - combinational pointer-based one-hot round-robin picker
//
// req  : request vector
// ptr  : index where the search starts (wraps at NREQ-1)
// grant: one-hot winner, all zero when no request is set
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant
);
    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - arbitrates sprite move requests onto a single move engine
//
// clk   : system clock, rising edge
// reset : asynchronous active-low reset
// bus   : move_scheduler_if.slave (requests, engine status, grant/ack/position outputs)
// Optional feature macro QBERT_PRIORITY_EN: requester 0 (Qbert) always wins when requesting.
module move_scheduler
    import qbert_pkg::*;
#(
    parameter  int NREQ        = 4,
    parameter  int POS_W       = qbert_pkg::POS_W,
    parameter  int TIMEOUT_CYC = 2**20,
    localparam int ID_W        = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input logic             clk,
    input logic             reset,
    move_scheduler_if.slave bus
);
    mv_state_t       state;
    logic [ID_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [NREQ-1:0] rr_grant;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] gidx;
    logic [1:0]      gdir;
    logic [ID_W-1:0] next_ptr;
    logic            cnt_last;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (rr_grant)
    );

`ifdef QBERT_PRIORITY_EN
    assign grant = bus.req[0] ? NREQ'(1) : rr_grant;
`else
    assign grant = rr_grant;
`endif

    always_comb begin
        gidx = '0;
        gdir = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gidx = ID_W'(i);
                gdir = bus.req_dir[2*i +: 2];
            end
        end
    end

    assign next_ptr = (bus.mv_id == ID_W'(NREQ - 1)) ? '0 : bus.mv_id + 1'b1;
    // The flag must be visible TIMEOUT_CYC cycles after START, so fire on the
    // edge where the counter would reach TIMEOUT_CYC-1.
    assign cnt_last = (cnt == CNT_W'(TIMEOUT_CYC - 2));
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            ptr             <= '0;
            cnt             <= '0;
            bus.mv_start    <= 1'b0;
            bus.mv_dir      <= 2'd0;
            bus.mv_id       <= '0;
            bus.ack         <= '0;
            bus.pos_out     <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.mv_start <= 1'b0;
            bus.ack      <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req && bus.done_move) begin
                        bus.mv_id    <= gidx;
                        bus.mv_dir   <= gdir;
                        bus.mv_start <= 1'b1;
                        cnt          <= '0;
                        state        <= START;
                    end
                end
                START: state <= WAIT_LOW;
                WAIT_LOW, WAIT_HIGH: begin
                    cnt <= cnt + 1'b1;
                    if (state == WAIT_LOW && !bus.done_move) begin
                        state <= WAIT_HIGH;
                    end else if (state == WAIT_HIGH && bus.done_move) begin
                        // Ack and position land together so both are visible in COMMIT.
                        for (int i = 0; i < NREQ; i++) begin
                            if (ID_W'(i) == bus.mv_id) begin
                                bus.ack[i]                   <= 1'b1;
                                bus.pos_out[i*POS_W +: POS_W] <= bus.position_qb;
                            end
                        end
                        state <= COMMIT;
                    end else if (cnt_last) begin
                        bus.timeout_err <= 1'b1;
                        ptr             <= next_ptr;
                        state           <= IDLE;
                    end
                end
                COMMIT: begin
                    ptr   <= next_ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - self-checking bench for move_scheduler
module tb_move_scheduler;
    import qbert_pkg::*;

`ifdef QBERT_PRIORITY_EN
    localparam bit PRI = 1'b1;
`else
    localparam bit PRI = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [27:0] exp_pos [4];

    move_scheduler_if #(.NREQ(4), .POS_W(28)) bus ();

    move_scheduler #(.NREQ(4), .POS_W(28), .TIMEOUT_CYC(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  dir;
        logic [27:0] pos;
        int          exp_id;
        logic [1:0]  exp_dir;
        bit          drop;
    } vec_t;

    vec_t vt [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [111:0] packed_pos();
        return {exp_pos[3], exp_pos[2], exp_pos[1], exp_pos[0]};
    endfunction

    task automatic wait_start(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.mv_start && n < 20);
        if (!bus.mv_start) n = -1;
    endtask

    // Engine model: drops done_move 2 cycles after mv_start, raises it 10 cycles later.
    task automatic finish_move(input int id, input logic [27:0] p, input bit drop,
                               input logic [1:0] edir);
        int n;
        step();
        step();
        bus.done_move = 1'b0;
        if (drop) bus.req[id] = 1'b0;
        bus.req_dir = ~bus.req_dir;
        repeat (10) step();
        chk("mv_dir_stable", bus.mv_dir, edir);
        bus.done_move   = 1'b1;
        bus.position_qb = p;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.ack == 4'b0 && n < 8);
        chk("ack_latency", n, 1);
        chk("ack_onehot", bus.ack, 4'b1 << id);
        bus.req = 4'b0;
        exp_pos[id] = p;
        chk("pos_out", bus.pos_out, packed_pos());
        step();
        chk("ack_single", bus.ack, 4'b0);
    endtask

    initial begin
        int n;
        int k;
        bit ack_seen;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4; i++) exp_pos[i] = '0;

        vt[0] = '{4'b1111, 8'b11_10_01_00, 28'h0000011, 0, 2'd0, 1'b0};
        vt[1] = '{4'b1111, 8'b11_10_01_00, 28'h0000022, PRI ? 0 : 1, PRI ? 2'd0 : 2'd1, 1'b0};
        vt[2] = '{4'b1111, 8'b11_10_01_00, 28'h0000033, PRI ? 0 : 2, PRI ? 2'd0 : 2'd2, 1'b0};
        vt[3] = '{4'b1111, 8'b11_10_01_00, 28'h0000044, PRI ? 0 : 3, PRI ? 2'd0 : 2'd3, 1'b0};
        vt[4] = '{4'b0010, 8'b11_10_01_00, 28'h0ABCDEF, 1, 2'd1, 1'b0};
        vt[5] = '{4'b1001, 8'b00_01_10_11, 28'h1234567, PRI ? 0 : 3, PRI ? 2'd3 : 2'd0, 1'b0};
        vt[6] = '{4'b0110, 8'b11_10_01_00, 28'h7654321, 1, 2'd1, 1'b0};
        vt[7] = '{4'b0100, 8'b11_10_01_00, 28'hFEDCBA9, 2, 2'd2, 1'b1};

        reset           = 1'b0;
        bus.req         = 4'b0;
        bus.req_dir     = 8'b0;
        bus.done_move   = 1'b1;
        bus.position_qb = 28'h0;
        #3;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_mv_start", bus.mv_start, 1'b0);
        chk("rst_pos_out", bus.pos_out, 112'b0);
        chk("rst_timeout", bus.timeout_err, 1'b0);
        step();
        reset = 1'b1;
        step();

        for (int v = 0; v < 8; v++) begin
            bus.req     = vt[v].req;
            bus.req_dir = vt[v].dir;
            wait_start(n);
            chk($sformatf("v%0d_start_lat", v), n, 1);
            chk($sformatf("v%0d_mv_id", v), bus.mv_id, vt[v].exp_id);
            chk($sformatf("v%0d_mv_dir", v), bus.mv_dir, vt[v].exp_dir);
            chk($sformatf("v%0d_busy", v), bus.busy, 1'b1);
            finish_move(vt[v].exp_id, vt[v].pos, vt[v].drop, vt[v].exp_dir);
        end

        // Engine busy while idle: no grant until done_move rises.
        bus.done_move = 1'b0;
        bus.req       = 4'b0001;
        bus.req_dir   = 8'b00_00_00_10;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.mv_start) k++;
        end
        chk("idle_engine_busy_no_start", k, 0);
        chk("idle_engine_busy_state", bus.busy, 1'b0);
        bus.done_move = 1'b1;
        wait_start(n);
        chk("idle_engine_busy_lat", n, 1);
        chk("idle_engine_busy_id", bus.mv_id, 0);
        finish_move(0, 28'h0555AAA, 1'b0, 2'd2);

        // Timeout: engine never drops done_move.
        bus.req     = 4'b0001;
        bus.req_dir = 8'b0;
        wait_start(n);
        chk("to_start_lat", n, 1);
        ack_seen = 1'b0;
        k = 0;
        while (k < 40 && !bus.timeout_err) begin
            step();
            k++;
            if (bus.ack != 4'b0) ack_seen = 1'b1;
        end
        chk("to_cycle", k, 16);
        chk("to_no_ack", ack_seen, 1'b0);
        chk("to_busy", bus.busy, 1'b0);
        chk("to_pos_unchanged", bus.pos_out, packed_pos());
        bus.req     = 4'b0010;
        bus.req_dir = 8'b00_00_11_00;
        wait_start(n);
        chk("to_next_grant_lat", n, 1);
        chk("to_next_grant_id", bus.mv_id, 1);
        chk("to_sticky", bus.timeout_err, 1'b1);
        finish_move(1, 28'h0BEEF01, 1'b0, 2'd3);

        // Reset in WAIT_HIGH, then a pending request is granted afresh.
        bus.req     = 4'b0100;
        bus.req_dir = 8'b00_01_00_00;
        wait_start(n);
        chk("rm_start_id", bus.mv_id, 2);
        step();
        step();
        bus.done_move = 1'b0;
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) exp_pos[i] = '0;
        chk("rm_busy", bus.busy, 1'b0);
        chk("rm_mv_id", bus.mv_id, 0);
        chk("rm_mv_dir", bus.mv_dir, 2'd0);
        chk("rm_ack", bus.ack, 4'b0);
        chk("rm_pos_out", bus.pos_out, 112'b0);
        chk("rm_timeout", bus.timeout_err, 1'b0);
        step();
        reset         = 1'b1;
        bus.done_move = 1'b1;
        wait_start(n);
        chk("rm_regrant_lat", n, 1);
        chk("rm_regrant_id", bus.mv_id, 2);
        chk("rm_regrant_dir", bus.mv_dir, 2'd1);
        finish_move(2, 28'h0C0FFEE, 1'b0, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
